// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the banked Wishbone RAM bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  localparam int DRAM_BANK          = 0;
  localparam int IRAM_BANK          = 1;
  localparam int DEF_BANK_SEL_LSB   = 13;
  localparam int DEF_BANK_SEL_WIDTH = 4;

  // Upper bound on banks supported by bank_onehot; callers slice the result.
  localparam int MAX_BANKS = 64;

  function automatic logic [MAX_BANKS-1:0] bank_onehot(input int unsigned idx);
    return MAX_BANKS'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_ram_rdata_mux.sv
// NUM_BANKS-to-1 read-data mux selected by the latched bank index.
// Latency: combinational.
// Backpressure: none; pure datapath.
// Ports: rdata_all (all bank read words, bank i at [i*DATA_WIDTH +: DATA_WIDTH]),
//        bank_idx (selected bank), rdata (selected word).
module wb_ram_rdata_mux
  import wb_ram_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 1
) (
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata_all,
  input  logic [IDX_WIDTH-1:0]            bank_idx,
  output logic [DATA_WIDTH-1:0]           rdata
);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_idx == IDX_WIDTH'(i)) rdata = rdata_all[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/wb_banked_ram_interface.sv
// Wishbone classic slave fronting NUM_BANKS synchronous RAM banks, with error response.
// Latency: write ack 2 cycles after the sampling edge, read ack RAM_RD_LATENCY+1, err 1.
// Backpressure: one transfer at a time; wb_ack_o/wb_err_o terminate, busy_o while not idle.
// Ports: wb_clk_i/rst_i clock and sync reset; en_i block enable; wb_* Wishbone slave;
//        ram_addr_o/ram_wdata_o/ram_be_o shared by banks; ram_en_o/ram_we_o per bank;
//        ram_rdata_i concatenated bank read data; busy_o high when state != IDLE.
module wb_banked_ram_interface
  import wb_ram_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_SEL_LSB   = DEF_BANK_SEL_LSB,
  parameter int BANK_SEL_WIDTH = DEF_BANK_SEL_WIDTH,
  parameter int RAM_ADDR_WIDTH = 11,
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic                               wb_clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic [WB_ADDR_WIDTH-1:0]           wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]           wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0]           wb_dat_o,
  input  logic                               wb_we_i,
  input  logic [WB_DATA_WIDTH/8-1:0]         wb_sel_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_cyc_i,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic [RAM_ADDR_WIDTH-1:0]          ram_addr_o,
  output logic [WB_DATA_WIDTH-1:0]           ram_wdata_o,
  output logic [WB_DATA_WIDTH/8-1:0]         ram_be_o,
  output logic [NUM_BANKS-1:0]               ram_en_o,
  output logic [NUM_BANKS-1:0]               ram_we_o,
  input  logic [NUM_BANKS*WB_DATA_WIDTH-1:0] ram_rdata_i,
  output logic                               busy_o
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam int OFS   = $clog2(SEL_W);
  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W = $clog2(RAM_RD_LATENCY + 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          bank_q, bank_d;
  logic                      we_q, we_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WB_DATA_WIDTH-1:0]  dat_d, rd_sel;
  logic                      ack_d, err_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_d;
  logic [WB_DATA_WIDTH-1:0]  wdata_d;
  logic [SEL_W-1:0]          be_d;
  logic [NUM_BANKS-1:0]      en_d, rwe_d;

  logic [BANK_SEL_WIDTH-1:0] bank_sel;
  logic [31:0]               bank_ext;
  logic                      mapped;
  logic [MAX_BANKS-1:0]      req_oh;
  logic                      unused_bits;

  assign bank_sel    = wb_adr_i[BANK_SEL_LSB +: BANK_SEL_WIDTH];
  assign bank_ext    = 32'(bank_sel);
  assign mapped      = bank_ext < 32'(NUM_BANKS);
  assign req_oh      = bank_onehot(bank_ext);
  // Byte-offset and upper address bits are deliberately ignored by the decode.
  assign unused_bits = ^{wb_adr_i, req_oh};

  wb_ram_rdata_mux #(
    .NUM_BANKS (NUM_BANKS),
    .DATA_WIDTH(WB_DATA_WIDTH),
    .IDX_WIDTH (IDX_W)
  ) u_rdata_mux (
    .rdata_all(ram_rdata_i),
    .bank_idx (bank_q),
    .rdata    (rd_sel)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    dat_d   = wb_dat_o;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = ram_addr_o;
    wdata_d = ram_wdata_o;
    be_d    = ram_be_o;
    en_d    = '0;
    rwe_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (!mapped || !en_i) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            bank_d  = bank_sel[IDX_W-1:0];
            we_d    = wb_we_i;
            addr_d  = wb_adr_i[OFS +: RAM_ADDR_WIDTH];
            wdata_d = wb_dat_i;
            be_d    = wb_we_i ? wb_sel_i : '1;
            en_d    = req_oh[NUM_BANKS-1:0];
            rwe_d   = wb_we_i ? req_oh[NUM_BANKS-1:0] : '0;
          end
        end
      end
      ST_ACCESS: begin
        // A dropped cycle abandons the ack; a write strobe already went out.
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (we_q || RAM_RD_LATENCY == 1) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          if (!we_q) dat_d = rd_sel;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RAM_RD_LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          dat_d   = rd_sel;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      wb_dat_o    <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_be_o    <= '0;
      ram_en_o    <= '0;
      ram_we_o    <= '0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      wb_dat_o    <= dat_d;
      wb_ack_o    <= ack_d;
      wb_err_o    <= err_d;
      ram_addr_o  <= addr_d;
      ram_wdata_o <= wdata_d;
      ram_be_o    <= be_d;
      ram_en_o    <= en_d;
      ram_we_o    <= rwe_d;
      busy_o      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_wb_banked_ram_interface.sv
// Self-checking bench: one bridge with read latency 1, one with latency 3, each
// on its own behavioural RAM; expectations come from a byte-level memory model.
module tb_wb_banked_ram_interface;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, blk_en, we;
  logic [31:0] adr, wdat_i;
  logic [3:0]  sel;
  logic        cyc [2];
  logic        stb [2];

  logic [31:0] dat_o [2];
  logic        ack   [2];
  logic        err   [2];
  logic [10:0] raddr [2];
  logic [31:0] rwdat [2];
  logic [3:0]  rbe   [2];
  logic [1:0]  ren   [2];
  logic [1:0]  rwe   [2];
  logic        busy  [2];
  logic [63:0] rdata0, rdata1;

  wb_banked_ram_interface #(.RAM_RD_LATENCY(1)) u_dut_l1 (
    .wb_clk_i(clk), .rst_i(rst), .en_i(blk_en), .wb_adr_i(adr), .wb_dat_i(wdat_i),
    .wb_dat_o(dat_o[0]), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .ram_addr_o(raddr[0]), .ram_wdata_o(rwdat[0]),
    .ram_be_o(rbe[0]), .ram_en_o(ren[0]), .ram_we_o(rwe[0]), .ram_rdata_i(rdata0),
    .busy_o(busy[0]));

  wb_banked_ram_interface #(.RAM_RD_LATENCY(3)) u_dut_l3 (
    .wb_clk_i(clk), .rst_i(rst), .en_i(blk_en), .wb_adr_i(adr), .wb_dat_i(wdat_i),
    .wb_dat_o(dat_o[1]), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .ram_addr_o(raddr[1]), .ram_wdata_o(rwdat[1]),
    .ram_be_o(rbe[1]), .ram_en_o(ren[1]), .ram_we_o(rwe[1]), .ram_rdata_i(rdata1),
    .busy_o(busy[1]));

  // Behavioural RAMs. Data is driven only in the cycle it is promised
  // (latency-1 cycles after the strobe cycle); otherwise a poison pattern.
  logic [31:0] tmem0 [2][2048] = '{default: '0};
  logic [31:0] tmem1 [2][2048] = '{default: '0};
  logic [1:0]  p1_v, p2_v;
  logic [31:0] p1_d [2];
  logic [31:0] p2_d [2];

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (ren[0][b] && rwe[0][b] && rbe[0][k]) tmem0[b][raddr[0]][8*k +: 8] <= rwdat[0][8*k +: 8];
        if (ren[1][b] && rwe[1][b] && rbe[1][k]) tmem1[b][raddr[1]][8*k +: 8] <= rwdat[1][8*k +: 8];
      end
      p1_v[b] <= ren[1][b] & ~rwe[1][b];
      p1_d[b] <= tmem1[b][raddr[1]];
      p2_v[b] <= p1_v[b];
      p2_d[b] <= p1_d[b];
    end
  end

  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    for (int b = 0; b < 2; b++) begin
      rdata0[b*32 +: 32] = (ren[0][b] && !rwe[0][b]) ? tmem0[b][raddr[0]] : 32'hBAD0_BAD0;
      rdata1[b*32 +: 32] = p2_v[b] ? p2_d[b] : 32'hBAD1_BAD1;
    end
  end

  // Reference model: plain word arrays per DUT/bank plus last returned read word.
  logic [31:0] ref_mem [2][2][2048] = '{default: '0};
  logic [31:0] last_rd [2];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk(tag, {dat_o[d], rwdat[d]}, 64'h0);
    chk(tag, {42'h0, ack[d], err[d], raddr[d], rbe[d], ren[d], rwe[d], busy[d]}, 64'h0);
  endtask

  // One Wishbone transfer; the master drops cyc/stb on ack or err (or in the
  // ACCESS cycle when abort is set). Everything is measured in cycles after
  // the sampling edge N.
  task automatic run_txn(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] s, input logic en_v, input logic abort);
    int lat, bnk, wrd, ack_n, ack_c, err_c, en_n, busy_n, both, exp_ack;
    logic mapped;
    logic [31:0] exp_rd, got_rd;
    lat = (d == 0) ? 1 : 3;
    bnk = int'(a[16:13]);
    wrd = int'(a[12:2]);
    mapped = en_v && (bnk < 2);
    exp_rd = 32'h0;
    if (mapped) exp_rd = ref_mem[d][bnk][wrd];
    got_rd = 32'h0;
    ack_n = 0; ack_c = 0; err_c = 0; en_n = 0; busy_n = 0; both = 0;
    @(negedge clk);
    adr = a; wdat_i = wd; we = w; sel = s; blk_en = en_v; cyc[d] = 1'b1; stb[d] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (mapped) begin
          chk("ram_en", ren[d], (bnk == 1) ? 2'b10 : 2'b01);
          chk("ram_we", rwe[d], w ? ((bnk == 1) ? 2'b10 : 2'b01) : 2'b00);
          chk("ram_addr", raddr[d], a[12:2]);
          chk("ram_be", rbe[d], w ? s : 4'hF);
          if (w) chk("ram_wdata", rwdat[d], wd);
        end
        if (abort) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
      end
      if (ren[d] != 2'b00) en_n++;
      if (busy[d]) busy_n++;
      if (ack[d] && err[d]) both++;
      if (ack[d]) begin
        ack_n++;
        if (ack_c == 0) begin ack_c = c; got_rd = dat_o[d]; end
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end
      if (err[d]) begin
        if (err_c == 0) err_c = c;
        cyc[d] = 1'b0; stb[d] = 1'b0;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    exp_ack = (mapped && !abort) ? (w ? 2 : 1 + lat) : 0;
    chk("ack_cycle", ack_c, exp_ack);
    chk("ack_count", ack_n, (exp_ack != 0) ? 1 : 0);
    chk("err_cycle", err_c, mapped ? 0 : 1);
    chk("ram_en_cycles", en_n, mapped ? 1 : 0);
    chk("busy_cycles", busy_n, (mapped && !abort) ? (w ? 2 : lat + 1) : 1);
    chk("ack_err_both", both, 0);
    if (mapped && w) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) ref_mem[d][bnk][wrd][8*k +: 8] = wd[8*k +: 8];
    end
    if (mapped && !w && !abort) begin
      chk("rd_data", got_rd, exp_rd);
      last_rd[d] = exp_rd;
    end
    chk("dat_hold", dat_o[d], last_rd[d]);
  endtask

  // Held strobe on the latency-1 bridge: two reads, then a third cut by reset.
  task automatic run_b2b();
    int nack, a1c, a2c;
    logic [31:0] d1, d2, e1, e2;
    nack = 0; a1c = 0; a2c = 0; d1 = 32'h0; d2 = 32'h0;
    e1 = ref_mem[0][0][5];
    e2 = ref_mem[0][1][6];
    @(negedge clk);
    adr = 32'h0000_0014; we = 1'b0; sel = 4'hF; blk_en = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (ack[0]) begin
        nack++;
        if (nack == 1) begin a1c = c; d1 = dat_o[0]; adr = 32'h0000_2018; end
        else if (nack == 2) begin a2c = c; d2 = dat_o[0]; adr = 32'h0000_001C; end
      end
      if (c == 7) begin
        chk("b2b_third_en", ren[0], 2'b01);
        rst = 1'b1;
      end
      if (c == 8) begin
        chk_zero(0, "b2b_reset_zero");
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      end
    end
    chk("b2b_ack1_cycle", a1c, 2);
    chk("b2b_ack2_cycle", a2c, 5);
    chk("b2b_ack_count", nack, 2);
    chk("b2b_data1", d1, e1);
    chk("b2b_data2", d2, e2);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  initial begin
    rst = 1'b1; blk_en = 1'b0; we = 1'b0; adr = '0; wdat_i = '0; sel = '0;
    cyc[0] = 1'b0; cyc[1] = 1'b0; stb[0] = 1'b0; stb[1] = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "reset_l1");
    chk_zero(1, "reset_l3");
    rst = 1'b0;

    // Full-word write to bank 1, then write/read on bank 0.
    run_txn(0, 32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0008, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0008, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    // Latency-3 bridge, bank 1.
    run_txn(1, 32'h0000_200C, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
    run_txn(1, 32'h0000_200C, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    // Unmapped bank and disabled block.
    run_txn(0, 32'h0000_4000, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0);
    run_txn(1, 32'h0000_4000, 1'b1, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0);
    // Byte-lane merge and an all-lanes-off write.
    run_txn(0, 32'h0000_0010, 1'b1, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0010, 1'b1, 32'h1122_3344, 4'b0100, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0);
    run_txn(0, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    // Aborted write still lands; aborted read gives no ack.
    run_txn(1, 32'h0000_2020, 1'b1, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b1);
    run_txn(1, 32'h0000_2020, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    run_txn(1, 32'h0000_0020, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
    // Back-to-back reads and reset mid-transfer.
    run_txn(0, 32'h0000_0014, 1'b1, 32'h0BAD_CAFE, 4'hF, 1'b1, 1'b0);
    run_txn(0, 32'h0000_2018, 1'b1, 32'h7654_3210, 4'hF, 1'b1, 1'b0);
    run_b2b();
    @(negedge clk);
    chk_zero(1, "reset_l3_midrun");

    // Randomised traffic on a small address window for plenty of hits.
    for (int i = 0; i < 80; i++) begin
      int d, bsel;
      logic [31:0] a;
      d = i % 2;
      bsel = $urandom_range(0, 4);
      if (bsel >= 3) bsel = $urandom_range(2, 15);
      a = $urandom;
      a[16:13] = 4'(bsel);
      a[12:2] = 11'($urandom_range(0, 7));
      run_txn(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_banked_ram_interface.md
Name: wb_banked_ram_interface

Overview:
Single-clock Wishbone classic slave bridging one bus master to NUM_BANKS synchronous RAM banks (bank 0 DRAM, bank 1 IRAM by default, more banks optional).
Adds over the previous RAM bridge:
- parametrised bank count and RAM read latency
- byte-lane write enables
- per-bank enables
- Wishbone error response for unmapped or disabled accesses
Sits between the core's Wishbone interconnect and the IRAM/DRAM macros.

Parameters:
WB_ADDR_WIDTH, 32, Wishbone address width
WB_DATA_WIDTH, 32, data width; multiple of 8
NUM_BANKS, 2, number of RAM banks; must be <= 2**BANK_SEL_WIDTH
BANK_SEL_LSB, 13, LSB of bank-select address field
BANK_SEL_WIDTH, 4, width of bank-select field
RAM_ADDR_WIDTH, 11, RAM word-address width
RAM_RD_LATENCY, 1, cycles from ram_en_o to valid ram_rdata_i; must be >= 1

Ports:
wb_clk_i  in  1  single clock for all logic
rst_i  in  1  synchronous active-high reset
en_i  in  1  block enable
wb_adr_i  in  WB_ADDR_WIDTH  byte address
wb_dat_i  in  WB_DATA_WIDTH  write data
wb_dat_o  out  WB_DATA_WIDTH  read data
wb_we_i  in  1  1=write, 0=read
wb_sel_i  in  WB_DATA_WIDTH/8  byte selects
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
ram_addr_o  out  RAM_ADDR_WIDTH  word address, shared by all banks
ram_wdata_o  out  WB_DATA_WIDTH  write data, shared by all banks
ram_be_o  out  WB_DATA_WIDTH/8  byte enables
ram_en_o  out  NUM_BANKS  per-bank access strobe
ram_we_o  out  NUM_BANKS  per-bank write enable
ram_rdata_i  in  NUM_BANKS*WB_DATA_WIDTH  bank read data; bank i at slice [i*WB_DATA_WIDTH +: WB_DATA_WIDTH]
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous, active-high on rst_i. All outputs 0, state IDLE. Reset in any state abandons the transfer; no ack or err is issued for it.
- Decode:
  - bank = wb_adr_i[BANK_SEL_LSB +: BANK_SEL_WIDTH]
  - word address = wb_adr_i[OFS +: RAM_ADDR_WIDTH], where OFS = $clog2(WB_DATA_WIDTH/8)
  - byte-offset bits are ignored
  - unmapped when bank >= NUM_BANKS
- FSM states: IDLE, ACCESS, WAIT, RESP, ERR. All outputs are registered.
- IDLE: samples wb_cyc_i & wb_stb_i at edge N.
  - If unmapped, or en_i=0: go to ERR.
  - Else: latch address, data and sel; go to ACCESS.
- ACCESS (cycle N+1), exactly one cycle:
  - ram_en_o = one-hot(bank)
  - ram_we_o = one-hot(bank) & wb_we_i
  - ram_be_o = wb_sel_i on writes, all ones on reads
  - ram_addr_o, ram_wdata_o valid
  - Next state: writes go to RESP. Reads go to WAIT when RAM_RD_LATENCY > 1, else to RESP.
- WAIT: held for RAM_RD_LATENCY-1 cycles by a down-counter of width $clog2(RAM_RD_LATENCY+1). ram_en_o and ram_we_o are 0.
- Read capture: at the edge ending the cycle RAM_RD_LATENCY after ACCESS began, wb_dat_o <= selected bank slice.
- RESP: wb_ack_o=1 for exactly one cycle, then IDLE.
  - Read ack at N+1+RAM_RD_LATENCY.
  - Write ack at N+2.
- ERR (cycle N+1): wb_err_o=1 for one cycle, no RAM strobe, then IDLE.
- wb_dat_o holds the last read value until the next read capture. Writes and errors do not change it.
- Back-to-back: RESP always returns to IDLE, so a held stb is re-sampled only in the IDLE cycle. There is no double issue.
- Abort: if wb_cyc_i=0 during ACCESS or WAIT:
  - a RAM write already issued completes
  - ack is suppressed
  - FSM goes to IDLE at the next edge
- wb_ack_o and wb_err_o are never both high.
- wb_sel_i=0 on a write: RAM access is issued with ram_be_o=0, then a normal ack.

Decomposition:
- Package wb_ram_pkg:
  - state enum type
  - DRAM_BANK=0, IRAM_BANK=1
  - default BANK_SEL_LSB and BANK_SEL_WIDTH
  - function bank_onehot(idx)
- Sub-module wb_ram_rdata_mux: parametrised NUM_BANKS-to-1 read-data mux selected by the latched bank index.

Test Plan:
1. Write 0xDEADBEEF to 0x0000_2004, sel=0xF, L=1 -> at N+1: ram_en_o=2'b10, ram_we_o=2'b10, ram_addr_o=1, ram_be_o=0xF, ram_wdata_o=0xDEADBEEF. At N+2: single-cycle ack, err=0.
2. Read 0x0000_0008, bank0 rdata=0x12345678, L=1 -> at N+1: ram_en_o=2'b01, ram_we_o=0, ram_addr_o=2. At N+2: ack with wb_dat_o=0x12345678.
3. RAM_RD_LATENCY=3, read 0x0000_200C -> ram_en_o high only at N+1, busy_o high N+1..N+4, ack with bank1 data at N+4.
4. Address 0x0000_4000 (bank field 2), and separately en_i=0 to 0x0 -> err at N+1 for one cycle; ram_en_o stays 0; no ack.
5. Byte write sel=4'b0100 to 0x0000_0010 -> ram_be_o=4'b0100, ram_addr_o=4. A subsequent read returns the modelled merged word.
6. Back-to-back reads with stb re-presented immediately -> acks at N+2 and N+5. rst_i at N+1 of a third read -> no ack, all outputs 0 at the next edge.
